eth_tx_frame_src: RTL and testbench
===================================

// Module: eth_tx_frame_src
// PURPOSE
// - Transmit-side counterpart of the TSE MAC receive stream: builds Ethernet II frames and drives them into the MAC Avalon-ST tx port.
// - Inputs: a start pulse with header fields, then a 32-bit payload stream.
// - Output: SOP/EOP/empty-framed 32-bit beats, with 2-byte SHIFT16 lead-in. The MAC appends the FCS.
// - Sits between the application datapath and nios_sys tx_* in the sysclk domain.
// PARAMETERS
// - MAX_LEN   1500  maximum payload bytes accepted
// - MIN_PAY   46    minimum payload bytes after padding (60-byte frame w/o FCS)
// PORTS
// - clk          in   1   system clock, 100 MHz; all logic on rising edge
// - rst_n        in   1   asynchronous active-low reset
// - i_start      in   1   one-cycle frame request; sampled only in IDLE
// - i_len        in   11  payload length in bytes, latched on accepted i_start
// - i_dst_mac    in   48  destination MAC, latched on i_start; [47:40] sent first
// - i_src_mac    in   48  source MAC, latched on i_start
// - i_eth_type   in   16  EtherType, latched on i_start
// - o_busy       out  1   high from accepted start through last beat accepted
// - o_reject     out  1   one-cycle pulse when i_start is refused
// - i_pl_data    in   32  payload word; [31:24] is the first byte on the wire
// - i_pl_vld     in   1   payload word valid
// - o_pl_rdy     out  1   payload word consumed on i_pl_vld & o_pl_rdy
// - o_tx_data    out  32  to MAC tx_data; big-endian byte order
// - o_tx_sop     out  1   to MAC tx_startofpacket
// - o_tx_eop     out  1   to MAC tx_endofpacket
// - o_tx_empty   out  2   to MAC tx_empty; valid only with eop
// - o_tx_err     out  1   to MAC tx_error; constant 0
// - o_tx_vld     out  1   to MAC tx_valid
// - i_tx_rdy     in   1   from MAC tx_ready
// - o_frame_cnt  out  16  completed frames; wraps at 0xFFFF->0
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0, including o_tx_vld, o_pl_rdy, o_busy and o_frame_cnt.
// - FSM states: IDLE -> HDR (4 beats) -> PAY -> [PAD] -> IDLE.
// - A beat transfers when o_tx_vld & i_tx_rdy.
// - The output register holds data/sop/eop/empty stable while o_tx_vld & !i_tx_rdy.
// - Start acceptance: in IDLE, i_start with 1<=i_len<=MAX_LEN is accepted and latches all header fields.
//   - The first beat (o_tx_sop=1) is valid the next cycle; o_busy rises on that same cycle.
// - Start rejection:
//   - i_len==0 or i_len>MAX_LEN -> o_reject pulses next cycle; no frame is sent.
//   - i_start while busy is ignored, with no reject pulse.
// - HDR beats:
//   - beat 0 = {16'h0000, dst[47:32]}
//   - beat 1 = dst[31:0]
//   - beat 2 = src[47:16]
//   - beat 3 = {src[15:0], type}
// - PAY: N = ceil(len/4) words.
//   - o_pl_rdy = state PAY & words_taken<N & (!o_tx_vld | i_tx_rdy).
//   - An input bubble (i_pl_vld=0) deasserts o_tx_vld; the frame is not aborted.
//   - Last word: bytes beyond len are forced to 0.
// - Effective length: L = len with padding off, max(len,MIN_PAY) with padding on. Total payload beats W = ceil(L/4).
// - EOP: o_tx_eop on payload beat W-1; o_tx_empty = (4 - L%4)%4. o_tx_empty=0 on non-eop beats.
// - Frame count: o_frame_cnt increments when the eop beat transfers.
//   - Return to IDLE happens on that same cycle; o_busy falls the next cycle.
// - Back-to-back: a start accepted in the first IDLE cycle gives a sop beat with no extra gap.
// - Length counter: 11-bit byte count and 9-bit word counters; there is no wrap within a frame.
// - Reset mid-frame: asserting rst_n low aborts immediately and returns to reset values.
//   - The MAC receives a truncated stream (no eop); this is acceptable only at system reset.
// CONFIGURATION
// - `define ETH_TX_PAD_EN:
//   - defined: when len<MIN_PAY, PAD state emits zero words after PAY up to W beats; L = max(len,MIN_PAY).
//   - undefined: no PAD state; L = len and frames go out short (MAC pads).
// TESTING
// - len=64, dst=FF..FF, src=00_11_22_33_44_55, type=0x0800, tx_rdy=1 -> 20 beats; beat0=0000FFFF, sop on beat 0, eop on beat 19, empty=0, frame_cnt=1.
// - len=5 with PAD_EN -> 4 HDR + 12 payload beats; byte 5 onward zero; eop beat 15, empty=2. Without PAD_EN -> 6 beats, eop empty=3.
// - len=1501 or len=0 -> o_reject pulse, o_tx_vld stays 0, frame_cnt unchanged.
// - len=100, i_tx_rdy random 50% -> beats are held stable while not ready, no beat lost or duplicated, eop on beat 28.
// - Payload i_pl_vld low for 7 cycles mid-frame -> o_tx_vld low for those cycles, data resumes in order, frame_cnt+1.
// - Second i_start during frame -> ignored, no reject; a start accepted right after eop -> next sop with no gap; frame_cnt=0xFFFF -> wraps to 0.

Source files
------------

// File: rtl/eth_tx_frame_src.sv
// rtl/eth_tx_frame_src.sv - Ethernet II frame builder feeding the TSE MAC Avalon-ST tx port (SHIFT16 lead-in).
// Optional feature macro: ETH_TX_PAD_EN (zero-pads short payloads up to MIN_PAY bytes).
module eth_tx_frame_src #(
  parameter int MAX_LEN = 1500
`ifdef ETH_TX_PAD_EN
  , parameter int MIN_PAY = 46
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [10:0] i_len,
  input  logic [47:0] i_dst_mac,
  input  logic [47:0] i_src_mac,
  input  logic [15:0] i_eth_type,
  output logic        o_busy,
  output logic        o_reject,
  input  logic [31:0] i_pl_data,
  input  logic        i_pl_vld,
  output logic        o_pl_rdy,
  output logic [31:0] o_tx_data,
  output logic        o_tx_sop,
  output logic        o_tx_eop,
  output logic [1:0]  o_tx_empty,
  output logic        o_tx_err,
  output logic        o_tx_vld,
  input  logic        i_tx_rdy,
  output logic [15:0] o_frame_cnt
);

`ifdef ETH_TX_PAD_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_PAD} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} state_t;
`endif

  state_t      state_q, state_d;
  logic [47:0] dst_q, dst_d, src_q, src_d;
  logic [15:0] type_q, type_d;
  logic [8:0]  n_words_q, n_words_d, w_beats_q, w_beats_d, pay_cnt_q, pay_cnt_d;
  logic [1:0]  tail_q, tail_d, empty_q, empty_d, hdr_idx_q, hdr_idx_d;
  logic [31:0] data_q, data_d;
  logic        sop_q, sop_d, eop_q, eop_d, vld_q, vld_d;
  logic [1:0]  out_empty_q, out_empty_d;
  logic        busy_q, busy_d, reject_q, reject_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic [10:0] eff_len;
  logic [8:0]  n_words_in, w_beats_in;
  logic        len_ok, can_load, pl_rdy, is_eop, is_last;

`ifdef ETH_TX_PAD_EN
  assign eff_len = (i_len < 11'(MIN_PAY)) ? 11'(MIN_PAY) : i_len;
`else
  assign eff_len = i_len;
`endif

  assign len_ok     = (i_len != 11'd0) && (i_len <= 11'(MAX_LEN));
  assign n_words_in = i_len[10:2] + {8'd0, |i_len[1:0]};
  assign w_beats_in = eff_len[10:2] + {8'd0, |eff_len[1:0]};
  // The output register may reload whenever it is empty or its beat is leaving.
  assign can_load   = !vld_q || i_tx_rdy;
  assign pl_rdy     = (state_q == S_PAY) && (pay_cnt_q < n_words_q) && can_load;
  assign is_eop     = (pay_cnt_q == w_beats_q - 9'd1);
  assign is_last    = (pay_cnt_q == n_words_q - 9'd1);

  function automatic logic [31:0] tail_mask(input logic [1:0] nb);
    case (nb)
      2'd1:    tail_mask = 32'hFF00_0000;
      2'd2:    tail_mask = 32'hFFFF_0000;
      2'd3:    tail_mask = 32'hFFFF_FF00;
      default: tail_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    dst_d       = dst_q;
    src_d       = src_q;
    type_d      = type_q;
    n_words_d   = n_words_q;
    w_beats_d   = w_beats_q;
    pay_cnt_d   = pay_cnt_q;
    tail_d      = tail_q;
    empty_d     = empty_q;
    hdr_idx_d   = hdr_idx_q;
    data_d      = data_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    vld_d       = vld_q;
    out_empty_d = out_empty_q;
    frame_cnt_d = frame_cnt_q;
    reject_d    = 1'b0;

    if (can_load) begin
      vld_d       = 1'b0;
      sop_d       = 1'b0;
      eop_d       = 1'b0;
      out_empty_d = 2'd0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (len_ok) begin
            dst_d     = i_dst_mac;
            src_d     = i_src_mac;
            type_d    = i_eth_type;
            n_words_d = n_words_in;
            w_beats_d = w_beats_in;
            tail_d    = i_len[1:0];
            empty_d   = 2'(~eff_len[1:0] + 2'd1);
            pay_cnt_d = 9'd0;
            hdr_idx_d = 2'd1;
            data_d    = {16'h0000, i_dst_mac[47:32]};
            sop_d     = 1'b1;
            vld_d     = 1'b1;
            state_d   = S_HDR;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      S_HDR: begin
        if (can_load) begin
          vld_d     = 1'b1;
          hdr_idx_d = hdr_idx_q + 2'd1;
          case (hdr_idx_q)
            2'd1:    data_d = dst_q[31:0];
            2'd2:    data_d = src_q[47:16];
            default: data_d = {src_q[15:0], type_q};
          endcase
          if (hdr_idx_q == 2'd3) state_d = S_PAY;
        end
      end
      S_PAY: begin
        if (pl_rdy && i_pl_vld) begin
          data_d      = is_last ? (i_pl_data & tail_mask(tail_q)) : i_pl_data;
          vld_d       = 1'b1;
          eop_d       = is_eop;
          out_empty_d = is_eop ? empty_q : 2'd0;
          pay_cnt_d   = pay_cnt_q + 9'd1;
`ifdef ETH_TX_PAD_EN
          if (is_last && (w_beats_q != n_words_q)) state_d = S_PAD;
`endif
        end
      end
`ifdef ETH_TX_PAD_EN
      S_PAD: begin
        if (can_load && (pay_cnt_q < w_beats_q)) begin
          data_d      = 32'd0;
          vld_d       = 1'b1;
          eop_d       = is_eop;
          out_empty_d = is_eop ? empty_q : 2'd0;
          pay_cnt_d   = pay_cnt_q + 9'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Nothing is loaded after the eop beat, so its transfer always ends the frame.
    if (vld_q && i_tx_rdy && eop_q) begin
      state_d     = S_IDLE;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dst_q       <= 48'd0;
      src_q       <= 48'd0;
      type_q      <= 16'd0;
      n_words_q   <= 9'd0;
      w_beats_q   <= 9'd0;
      pay_cnt_q   <= 9'd0;
      tail_q      <= 2'd0;
      empty_q     <= 2'd0;
      hdr_idx_q   <= 2'd0;
      data_q      <= 32'd0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      vld_q       <= 1'b0;
      out_empty_q <= 2'd0;
      busy_q      <= 1'b0;
      reject_q    <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      type_q      <= type_d;
      n_words_q   <= n_words_d;
      w_beats_q   <= w_beats_d;
      pay_cnt_q   <= pay_cnt_d;
      tail_q      <= tail_d;
      empty_q     <= empty_d;
      hdr_idx_q   <= hdr_idx_d;
      data_q      <= data_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      vld_q       <= vld_d;
      out_empty_q <= out_empty_d;
      busy_q      <= busy_d;
      reject_q    <= reject_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_reject    = reject_q;
  assign o_pl_rdy    = pl_rdy;
  assign o_tx_data   = data_q;
  assign o_tx_sop    = sop_q;
  assign o_tx_eop    = eop_q;
  assign o_tx_empty  = out_empty_q;
  assign o_tx_err    = 1'b0;
  assign o_tx_vld    = vld_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_eth_tx_frame_src.sv
// tb/tb_eth_tx_frame_src.sv - directed self-checking bench for eth_tx_frame_src.
module tb_eth_tx_frame_src;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [10:0] i_len;
  logic [47:0] i_dst_mac, i_src_mac;
  logic [15:0] i_eth_type;
  logic        o_busy, o_reject;
  logic [31:0] i_pl_data;
  logic        i_pl_vld, o_pl_rdy;
  logic [31:0] o_tx_data;
  logic        o_tx_sop, o_tx_eop, o_tx_err, o_tx_vld;
  logic [1:0]  o_tx_empty;
  logic        i_tx_rdy;
  logic [15:0] o_frame_cnt;

  always #5 clk = ~clk;

  eth_tx_frame_src dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_len(i_len),
    .i_dst_mac(i_dst_mac), .i_src_mac(i_src_mac), .i_eth_type(i_eth_type),
    .o_busy(o_busy), .o_reject(o_reject),
    .i_pl_data(i_pl_data), .i_pl_vld(i_pl_vld), .o_pl_rdy(o_pl_rdy),
    .o_tx_data(o_tx_data), .o_tx_sop(o_tx_sop), .o_tx_eop(o_tx_eop),
    .o_tx_empty(o_tx_empty), .o_tx_err(o_tx_err), .o_tx_vld(o_tx_vld),
    .i_tx_rdy(i_tx_rdy), .o_frame_cnt(o_frame_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  localparam logic [47:0] DST_BC = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC_A  = 48'h0011_2233_4455;
  localparam logic [47:0] DST_B  = 48'h0203_0405_0607;

  function automatic logic [7:0] pb(input int i);
    return 8'(i * 7 + 3);
  endfunction

  function automatic logic [31:0] pl_word(input int k);
    return {pb(4*k), pb(4*k+1), pb(4*k+2), pb(4*k+3)};
  endfunction

  // monitor: captures transferred beats {sop,eop,empty,data}, checks stall stability
  logic [35:0] cap_q[$];
  logic [36:0] cur, held;
  logic        stall_q = 1'b0;
  int          gap_cnt = 0, rej_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      cur = {o_tx_vld, o_tx_sop, o_tx_eop, o_tx_empty, o_tx_data};
      if (stall_q) chk("hold", 64'(cur), 64'(held));
      stall_q = o_tx_vld & !i_tx_rdy;
      held    = cur;
      if (o_tx_vld && i_tx_rdy) cap_q.push_back(cur[35:0]);
      if (o_busy && !o_tx_vld) gap_cnt++;
      if (o_reject) rej_cnt++;
    end else begin
      stall_q = 1'b0;
    end
  end

  // payload source
  int pl_idx = 0, pl_n = 0, bub_at = -1, bub_left = 0;
  initial begin
    logic hs;
    i_pl_vld  = 1'b0;
    i_pl_data = 32'd0;
    forever begin
      @(negedge clk);
      hs = i_pl_vld & o_pl_rdy;
      @(posedge clk);
      #1;
      if (hs) pl_idx++;
      if (pl_idx < pl_n) begin
        if (pl_idx == bub_at && bub_left > 0) begin
          i_pl_vld = 1'b0;
          bub_left--;
        end else begin
          i_pl_vld  = 1'b1;
          i_pl_data = pl_word(pl_idx);
        end
      end else begin
        i_pl_vld = 1'b0;
      end
    end
  end

  // MAC ready: always 1 or random 50%
  bit rand_rdy = 1'b0;
  initial begin
    i_tx_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i_tx_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  logic [35:0] exp_q[$];
  int exp_cnt = 0;

  task automatic build_exp(input int len, input logic [47:0] dst, input logic [47:0] src,
                           input logic [15:0] typ);
    int l, w;
    logic [31:0] wd;
    logic eop;
    l = len;
`ifdef ETH_TX_PAD_EN
    if (l < 46) l = 46;
`endif
    w = (l + 3) / 4;
    exp_q.delete();
    exp_q.push_back({1'b1, 1'b0, 2'd0, 16'h0000, dst[47:32]});
    exp_q.push_back({4'd0, dst[31:0]});
    exp_q.push_back({4'd0, src[47:16]});
    exp_q.push_back({4'd0, src[15:0], typ});
    for (int k = 0; k < w; k++) begin
      wd = 32'd0;
      for (int b = 0; b < 4; b++)
        if (4*k + b < len) wd[31-8*b -: 8] = pb(4*k + b);
      eop = (k == w - 1);
      exp_q.push_back({1'b0, eop, eop ? 2'(4*w - l) : 2'd0, wd});
    end
  endtask

  task automatic cmp_frame(input string tag, input bit exact);
    logic [35:0] got;
    if (exact) chk({tag, "_nbeats"}, 64'(cap_q.size()), 64'(exp_q.size()));
    else       chk({tag, "_nbeats_min"}, 64'(cap_q.size() >= exp_q.size()), 64'd1);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (cap_q.size() == 0) break;
      got = cap_q.pop_front();
      chk($sformatf("%s_beat%0d", tag, k), 64'(got), 64'(exp_q[k]));
    end
  endtask

  task automatic pulse_start(input int len, input logic [47:0] dst, input logic [47:0] src,
                             input logic [15:0] typ);
    @(posedge clk);
    #1;
    i_start = 1'b1; i_len = 11'(len); i_dst_mac = dst; i_src_mac = src; i_eth_type = typ;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic start_frame(input int len, input logic [47:0] dst, input logic [47:0] src,
                             input logic [15:0] typ, input int bub);
    pl_idx   = 0;
    pl_n     = (len + 3) / 4;
    bub_at   = bub;
    bub_left = (bub >= 0) ? 7 : 0;
    pulse_start(len, dst, src, typ);
  endtask

  task automatic check_sop(input string tag);
    @(negedge clk);
    chk({tag, "_sop"}, {61'd0, o_tx_vld, o_tx_sop, o_busy}, 64'h7);
  endtask

  task automatic wait_eop(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (o_tx_vld && i_tx_rdy && o_tx_eop) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_eop_seen"}, 64'(ok), 64'd1);
  endtask

  task automatic finish_frame(input string tag, input int len, input logic [47:0] dst,
                              input logic [47:0] src, input logic [15:0] typ);
    wait_eop(tag);
    @(posedge clk);
    @(negedge clk);
    exp_cnt++;
    chk({tag, "_busy_fall"}, 64'(o_busy), 64'd0);
    chk({tag, "_frame_cnt"}, 64'(o_frame_cnt), 64'(exp_cnt));
    build_exp(len, dst, src, typ);
    cmp_frame(tag, 1'b1);
  endtask

  initial begin
    int g0, r0;
    rst_n = 1'b0; i_start = 1'b0; i_len = '0;
    i_dst_mac = '0; i_src_mac = '0; i_eth_type = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", 64'(o_tx_vld), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_pl_rdy", 64'(o_pl_rdy), 64'd0);
    chk("rst_frame_cnt", 64'(o_frame_cnt), 64'd0);
    chk("rst_flags", {57'd0, o_tx_sop, o_tx_eop, o_tx_empty, o_tx_err, o_reject}, 64'd0);
    chk("rst_data", 64'(o_tx_data), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // 64-byte frame, broadcast dst, tx always ready
    start_frame(64, DST_BC, SRC_A, 16'h0800, -1);
    @(negedge clk);
    chk("f1_beat0", 64'(o_tx_data), 64'h0000_FFFF);
    g0 = gap_cnt;
    finish_frame("f1", 64, DST_BC, SRC_A, 16'h0800);
    chk("f1_gaps", 64'(gap_cnt - g0), 64'd0);

    // 5-byte payload: masked tail, padded or short depending on build
    start_frame(5, DST_B, SRC_A, 16'h88B5, -1);
    check_sop("f2");
    finish_frame("f2", 5, DST_B, SRC_A, 16'h88B5);

    // refused lengths
    r0 = rej_cnt;
    pl_n = 0;
    pulse_start(1501, DST_B, SRC_A, 16'h0800);
    @(negedge clk);
    chk("rej1501_pulse", 64'(o_reject), 64'd1);
    @(negedge clk);
    chk("rej1501_once", {62'd0, o_reject, o_tx_vld}, 64'd0);
    pulse_start(0, DST_B, SRC_A, 16'h0800);
    @(negedge clk);
    chk("rej0_pulse", 64'(o_reject), 64'd1);
    repeat (3) @(negedge clk);
    chk("rej_idle", {62'd0, o_tx_vld, o_busy}, 64'd0);
    chk("rej_cnt", 64'(rej_cnt - r0), 64'd2);
    chk("rej_frame_cnt", 64'(o_frame_cnt), 64'(exp_cnt));

    // 100-byte frame against a randomly stalling MAC
    rand_rdy = 1'b1;
    start_frame(100, SRC_A, DST_B, 16'h86DD, -1);
    check_sop("f3");
    finish_frame("f3", 100, SRC_A, DST_B, 16'h86DD);
    rand_rdy = 1'b0;
    @(negedge clk);

    // 7-cycle payload bubble plus an ignored start while busy
    r0 = rej_cnt;
    start_frame(40, DST_B, SRC_A, 16'h0806, 4);
    check_sop("f4");
    g0 = gap_cnt;
    pulse_start(0, DST_BC, DST_BC, 16'hFFFF);
    finish_frame("f4", 40, DST_B, SRC_A, 16'h0806);
    chk("f4_bubble_gaps", 64'(gap_cnt - g0), 64'd7);
    chk("f4_no_reject", 64'(rej_cnt - r0), 64'd0);
    repeat (3) @(negedge clk);
    chk("f4_no_second", {62'd0, o_tx_vld, o_busy}, 64'd0);

    // back-to-back: start in the first IDLE cycle after eop
    start_frame(8, DST_BC, SRC_A, 16'h0800, -1);
    check_sop("f5");
    wait_eop("f5");
    start_frame(12, DST_B, SRC_A, 16'h0801, -1);
    @(negedge clk);
    chk("b2b_sop", {62'd0, o_tx_vld, o_tx_sop}, 64'h3);
    exp_cnt++;
    chk("f5_frame_cnt", 64'(o_frame_cnt), 64'(exp_cnt));
    build_exp(8, DST_BC, SRC_A, 16'h0800);
    cmp_frame("f5", 1'b0);
    finish_frame("f6", 12, DST_B, SRC_A, 16'h0801);

    // reset mid-frame
    start_frame(64, DST_BC, SRC_A, 16'h0800, -1);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    pl_n = 0;
    #1;
    chk("midrst_out", {61'd0, o_tx_vld, o_busy, o_pl_rdy}, 64'd0);
    chk("midrst_frame_cnt", 64'(o_frame_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
